// File: rtl/sha256_block_sequencer_if.sv
// sha256_block_sequencer_if: message stream, core handshake and digest bus of the block sequencer
// master: sequencer side (drives in_ready, core_*, digest*, block_count, busy, err)
// slave:  environment side (message source, SHA256_Top instance, digest consumer)
interface sha256_block_sequencer_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic         core_start;
    logic [511:0] core_block;
    logic [255:0] core_iv;
    logic [255:0] core_result;
    logic         core_done;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;
    logic [15:0]  block_count;
    logic         busy;
    logic         err;
    modport master (
        input  in_data, in_valid, in_last, core_result, core_done, digest_ready,
        output in_ready, core_start, core_block, core_iv, digest, digest_valid, block_count, busy, err
    );
    modport slave (
        output in_data, in_valid, in_last, core_result, core_done, digest_ready,
        input  in_ready, core_start, core_block, core_iv, digest, digest_valid, block_count, busy, err
    );
endinterface

// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer: buffers 16-word blocks of a pre-padded message, drives SHA256_Top and chains the hash
// Ports: clk, reset (sync, active high), bus (sha256_block_sequencer_if.master):
//   in_data/in_valid/in_ready/in_last  message word stream, in_last qualifies word 15
//   core_start/core_block/core_iv      request to the core, held for the whole RUN state
//   core_result/core_done              core response
//   digest/digest_valid/digest_ready   final hash output
//   block_count, busy, err             status
// Optional: SHA256_SEQ_WDT_EN adds a core-done watchdog of WDT_CYCLES clocks driving sticky err.
module sha256_block_sequencer #(
`ifdef SHA256_SEQ_WDT_EN
    parameter int WDT_CYCLES = 1024
`endif
) (
    input logic                        clk,
    input logic                        reset,
    sha256_block_sequencer_if.master   bus
);
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [1:0] {FILL, RUN, DRAIN, OUT} state_t;

    state_t       state;
    logic [3:0]   idx;
    logic [31:0]  words [16];
    logic [255:0] chain;
    logic         last_flag;
    logic         take;

    assign take = state == FILL && bus.in_valid && bus.in_ready;

    always_comb begin
        bus.core_block = '0;
        for (int i = 0; i < 16; i++) bus.core_block[32*(15-i) +: 32] = words[i];
    end

    assign bus.core_iv = chain;
    assign bus.busy    = !(state == FILL && idx == 4'd0 && bus.block_count == 16'd0);

    // Block buffer needs no reset: idx restarts at 0, so stale words are always overwritten.
    always_ff @(posedge clk)
        if (take) words[idx] <= bus.in_data;

`ifdef SHA256_SEQ_WDT_EN
    logic [31:0] wdt;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= FILL;
            idx              <= '0;
            chain            <= IV;
            last_flag        <= 1'b0;
            bus.block_count  <= '0;
            bus.in_ready     <= 1'b1;
            bus.core_start   <= 1'b0;
            bus.digest_valid <= 1'b0;
            bus.digest       <= '0;
`ifdef SHA256_SEQ_WDT_EN
            wdt              <= '0;
            bus.err          <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: if (take) begin
                    idx <= idx + 4'd1;
                    if (idx == 4'd15) begin
                        last_flag      <= bus.in_last;
                        state          <= RUN;
                        bus.in_ready   <= 1'b0;
                        bus.core_start <= 1'b1;
`ifdef SHA256_SEQ_WDT_EN
                        wdt            <= '0;
`endif
                    end
                end
                RUN: if (bus.core_done) begin
                    chain           <= bus.core_result;
                    bus.block_count <= bus.block_count + 16'(bus.block_count != 16'hFFFF);
                    if (last_flag) bus.digest <= bus.core_result;
                    bus.core_start  <= 1'b0;
                    state           <= DRAIN;
                end
`ifdef SHA256_SEQ_WDT_EN
                // Timeout abandons the message; DRAIN then falls through to FILL since last_flag is cleared.
                else if (wdt == 32'(WDT_CYCLES - 1)) begin
                    bus.err         <= 1'b1;
                    bus.core_start  <= 1'b0;
                    chain           <= IV;
                    bus.block_count <= '0;
                    last_flag       <= 1'b0;
                    state           <= DRAIN;
                end else wdt <= wdt + 32'd1;
`endif
                // Waiting for done to fall guarantees a fresh start edge for the next block.
                DRAIN: if (!bus.core_done) begin
                    state            <= last_flag ? OUT : FILL;
                    bus.digest_valid <= last_flag;
                    bus.in_ready     <= !last_flag;
                end
                OUT: if (bus.digest_ready) begin
                    bus.digest_valid <= 1'b0;
                    chain            <= IV;
                    last_flag        <= 1'b0;
                    bus.block_count  <= '0;
                    state            <= FILL;
                    bus.in_ready     <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
Multi-block message controller for SHA256_Top.
- Accepts a pre-padded message as a 32-bit word stream with valid/ready.
- Buffers each 16-word block and drives the core's start/done handshake.
- Chains the intermediate hash: standard IV for the first block, the previous core result for later blocks.
- Presents the final 256-bit digest on a valid/ready output.
- Sits between the message source (DMA/host FIFO) and the single SHA256_Top instance.

Parameters:
WDT_CYCLES, 1024, core-done watchdog limit in clocks; used only when SHA256_SEQ_WDT_EN is defined.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
in_data  in  32  message word, big-endian word order (first word is w0)
in_valid  in  1  in_data valid
in_ready  out  1  sequencer can accept a word
in_last  in  1  qualifies the 16th word of a block: that block is the message's final block
core_start  out  1  to SHA256_Top start_in, level held until done
core_block  out  512  to w0..w15; w0 = [511:480], w15 = [31:0]
core_iv  out  256  to A_i..H_i; A_i = [255:224], H_i = [31:0]
core_result  in  256  from sha256_result
core_done  in  1  from sha256_done
digest  out  256  final hash
digest_valid  out  1  digest valid
digest_ready  in  1  consumer accepts digest
block_count  out  16  blocks completed for the current message, saturating at 0xFFFF
busy  out  1  high in any state other than FILL with word index 0 and first block
err  out  1  sticky watchdog error; constant 0 without the macro

Behaviour:
- States: FILL, RUN, DRAIN, OUT.
- Reset values: state=FILL, word index=0, chain=IV (6A09E667 BB67AE85 3C6EF372 A54FF53A 510E527F 9B05688C 1F83D9AB 5BE0CD19), last_flag=0, block_count=0.
  - Outputs at reset: in_ready=1, core_start=0, digest_valid=0, digest=0, err=0.
  - Reset mid-operation aborts any message; partial block contents are discarded.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready, the word is written to buffer slot [index] and index increments.
  - in_last is sampled only on index 15 and stored as last_flag; it is ignored on other words.
  - The 16th accepted word moves to RUN on the next clock and resets index to 0.
  - No word is accepted in the cycle of that transition.
- RUN:
  - in_ready=0, core_start=1.
  - core_block = buffer; core_iv = chain register. Both are stable for the whole RUN state.
  - Minimum RUN duration is 1 cycle.
  - On the first cycle with core_done=1:
    - chain <= core_result; block_count increments (saturating).
    - If last_flag=1, digest <= core_result.
    - Go to DRAIN.
- DRAIN:
  - core_start=0; wait until core_done=0. This guarantees one start pulse per block, even if done is still high on entry.
  - Exit to OUT if last_flag, else to FILL.
- OUT:
  - digest_valid=1; digest held stable while digest_valid=1 and digest_ready=0.
  - On digest_ready:
    - digest_valid=0, chain<=IV, last_flag<=0, block_count<=0.
    - Go to FILL; in_ready rises on the following cycle.
- Input flow control: in_valid gaps of any length are allowed; the buffer holds the partial block indefinitely.
- Throughput per block: 16 input cycles + core latency + 1 RUN-exit cycle + ≥1 DRAIN cycle.
- No padding or length logic: the source supplies fully padded blocks.

Optional Feature:
SHA256_SEQ_WDT_EN.
- Defined:
  - A counter runs in RUN and clears on entry to RUN.
  - If it reaches WDT_CYCLES without core_done, then: err<=1 (sticky until reset), core_start<=0, chain<=IV, block_count<=0, last_flag<=0, and the state goes to DRAIN then FILL. No digest is produced.
  - The next message then proceeds normally.
- Undefined: no counter, err tied to 0, RUN waits for core_done indefinitely.

Test Plan:
- Single block "abc": 61626380, 14×00000000, 00000018 with in_last on word 15 → one core_start assertion; digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; block_count=1.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Second RUN has core_iv equal to the first core_result.
  - digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; block_count=2.
- Random in_valid gaps plus digest_ready held low 50 cycles on "hello world" → digest=b94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9, stable throughout the stall, exactly one handshake.
- Back-to-back messages: empty string, then "abc" → e3b0c442…7852b855, then ba7816bf…f20015ad; the second message's core_iv equals the standard IV.
- Reset asserted while in RUN during the first block of a two-block message:
  - Next cycle: core_start=0, in_ready=1, block_count=0.
  - Subsequent "abc" hashes correctly.
- With SHA256_SEQ_WDT_EN, WDT_CYCLES=32, stub core that never raises done:
  - err=1 after 32 RUN cycles; core_start drops; state returns to FILL; no digest_valid.
  - With a real core, "abc" then passes and err stays 1.
